// File: rtl/gpp_core_p.sv
`default_nettype none
// ============================================================================
//  Module   : gpp_core_p
//  Purpose  : Multicycle MIPS-subset processor. Instructions are fetched over
//             a memory port with an Ack handshake and executed against an
//             internal register file.
//  Revision : 1.0 - initial release
// ============================================================================
module gpp_core_p #(
    parameter int D_WIDTH  = 32,
    parameter int SA_WIDTH = 8,
    parameter int RA_WIDTH = 5,
    parameter int PROG_LEN = 256
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    output logic [SA_WIDTH-1:0] Addr,
    output logic                En,
    output logic                RW,
    input  logic [31:0]         Data,
    input  logic                Ack,
    output logic                Done,
    output logic                Err,
    input  logic [RA_WIDTH-1:0] DbgAddr,
    output logic [D_WIDTH-1:0]  DbgData
);

    localparam int                c_NREGS    = 2**RA_WIDTH;
    // One bit wider than the PC so that PROG_LEN == 2**SA_WIDTH is representable.
    localparam logic [SA_WIDTH:0] c_PROG_END = (SA_WIDTH+1)'(PROG_LEN);

    localparam logic [5:0] c_OP_RTYPE = 6'd0;
    localparam logic [5:0] c_OP_J     = 6'd2;
    localparam logic [5:0] c_OP_BEQ   = 6'd4;
    localparam logic [5:0] c_OP_ADDI  = 6'd8;
    localparam logic [5:0] c_OP_HALT  = 6'd63;

    localparam logic [5:0] c_FN_SLL   = 6'd0;
    localparam logic [5:0] c_FN_SRL   = 6'd2;
    localparam logic [5:0] c_FN_MUL   = 6'd24;
    localparam logic [5:0] c_FN_DIV   = 6'd26;
    localparam logic [5:0] c_FN_ADD   = 6'd32;
    localparam logic [5:0] c_FN_SUB   = 6'd34;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [SA_WIDTH-1:0] r_pc;
    logic [SA_WIDTH-1:0] r_pc_next;
    logic [31:0]         r_ir;
    logic [D_WIDTH-1:0]  r_regs [c_NREGS];
    logic [D_WIDTH-1:0]  r_op_a;
    logic [D_WIDTH-1:0]  r_op_b;
    logic [D_WIDTH-1:0]  r_result;
    logic [RA_WIDTH-1:0] r_wdst;
    logic                r_wen;
    logic                r_halt;
    logic                r_err;

    logic [5:0]          w_op;
    logic [5:0]          w_fn;
    logic [RA_WIDTH-1:0] w_rs;
    logic [RA_WIDTH-1:0] w_rt;
    logic [RA_WIDTH-1:0] w_rd;
    logic [4:0]          w_sh;
    logic [15:0]         w_imm;
    logic [D_WIDTH-1:0]  w_imm_ext;
    logic [D_WIDTH-1:0]  w_div;
    logic [SA_WIDTH-1:0] w_pc_inc;
    logic [SA_WIDTH-1:0] w_pc_branch;
    logic                w_at_end;

    logic [D_WIDTH-1:0]  w_result;
    logic [RA_WIDTH-1:0] w_wdst;
    logic                w_wen;
    logic [SA_WIDTH-1:0] w_pc_next;
    logic                w_halt;
    logic                w_err_set;

    assign w_op        = r_ir[31:26];
    assign w_rs        = r_ir[21 +: RA_WIDTH];
    assign w_rt        = r_ir[16 +: RA_WIDTH];
    assign w_rd        = r_ir[11 +: RA_WIDTH];
    assign w_sh        = r_ir[10:6];
    assign w_fn        = r_ir[5:0];
    assign w_imm       = r_ir[15:0];
    assign w_imm_ext   = D_WIDTH'(signed'(w_imm));
    assign w_div       = (r_op_b == '0) ? '1 : (r_op_a / r_op_b);
    assign w_pc_inc    = r_pc + SA_WIDTH'(1);
    assign w_pc_branch = w_pc_inc + SA_WIDTH'(signed'(w_imm));
    assign w_at_end    = ({1'b0, r_pc} == c_PROG_END);

    assign Addr    = r_pc;
    assign RW      = 1'b0;
    assign Done    = (r_state == S_HALT);
    assign Err     = r_err;
    assign DbgData = (DbgAddr == '0) ? '0 : r_regs[DbgAddr];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // En is decoded from state so it falls together with an asynchronous reset.
    always_comb begin
        w_state_next = r_state;
        En           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_at_end) begin
                    w_state_next = S_HALT;
                end else begin
                    En = 1'b1;
                    if (Ack) begin
                        w_state_next = S_DECODE;
                    end
                end
            end
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC:   w_state_next = S_WB;
            S_WB:     w_state_next = r_halt ? S_HALT : S_FETCH;
            S_HALT: begin
                if (Start) begin
                    w_state_next = S_FETCH;
                end
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_result  = '0;
        w_wdst    = w_rd;
        w_wen     = 1'b0;
        w_pc_next = w_pc_inc;
        w_halt    = 1'b0;
        w_err_set = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                w_wen = 1'b1;
                case (w_fn)
                    c_FN_SLL: w_result = r_op_b << w_sh;
                    c_FN_SRL: w_result = r_op_b >> w_sh;
                    c_FN_MUL: w_result = r_op_a * r_op_b;
                    c_FN_DIV: begin
                        w_result  = w_div;
                        w_err_set = (r_op_b == '0);
                    end
                    c_FN_ADD: w_result = r_op_a + r_op_b;
                    c_FN_SUB: w_result = r_op_a - r_op_b;
                    default: begin
                        w_wen     = 1'b0;
                        w_err_set = 1'b1;
                    end
                endcase
            end
            c_OP_ADDI: begin
                w_wdst   = w_rt;
                w_wen    = 1'b1;
                w_result = r_op_a + w_imm_ext;
            end
            c_OP_BEQ: begin
                if (r_op_a == r_op_b) begin
                    w_pc_next = w_pc_branch;
                end
            end
            c_OP_J:    w_pc_next = r_ir[SA_WIDTH-1:0];
            c_OP_HALT: w_halt    = 1'b1;
            default:   w_err_set = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pc      <= '0;
            r_pc_next <= '0;
            r_ir      <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_result  <= '0;
            r_wdst    <= '0;
            r_wen     <= 1'b0;
            r_halt    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (Start) begin
                        r_pc  <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (!w_at_end && Ack) begin
                        r_ir <= Data;
                    end
                end
                S_DECODE: begin
                    r_op_a <= (w_rs == '0) ? '0 : r_regs[w_rs];
                    r_op_b <= (w_rt == '0) ? '0 : r_regs[w_rt];
                end
                S_EXEC: begin
                    r_result  <= w_result;
                    r_wdst    <= w_wdst;
                    r_wen     <= w_wen;
                    r_pc_next <= w_pc_next;
                    r_halt    <= w_halt;
                    if (w_err_set) begin
                        r_err <= 1'b1;
                    end
                end
                S_WB: r_pc <= r_pc_next;
                default: ;
            endcase
        end
    end

    // R0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_WB && r_wen && r_wdst != '0) begin
            r_regs[r_wdst] <= r_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpp_core_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpp_core_p
//  Purpose  : Directed bench for gpp_core_p with an instruction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpp_core_p;

    localparam int SA_WIDTH = 8;
    localparam int RA_WIDTH = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start_a = 1'b0;
    logic                start_b = 1'b0;
    logic [31:0]         data = 32'd0;
    logic                ack = 1'b0;
    logic [RA_WIDTH-1:0] dbg_addr = '0;

    logic [SA_WIDTH-1:0] addr_a, addr_b;
    logic                en_a, en_b, rw_a, rw_b, done_a, done_b, err_a, err_b;
    logic [31:0]         dbg_a, dbg_b;

    gpp_core_p #(.D_WIDTH(32), .SA_WIDTH(SA_WIDTH), .RA_WIDTH(RA_WIDTH), .PROG_LEN(256)) dut_a (
        .Clk(clk), .Rst(rst_n), .Start(start_a), .Addr(addr_a), .En(en_a), .RW(rw_a),
        .Data(data), .Ack(ack), .Done(done_a), .Err(err_a), .DbgAddr(dbg_addr), .DbgData(dbg_a)
    );

    gpp_core_p #(.D_WIDTH(32), .SA_WIDTH(SA_WIDTH), .RA_WIDTH(RA_WIDTH), .PROG_LEN(4)) dut_b (
        .Clk(clk), .Rst(rst_n), .Start(start_b), .Addr(addr_b), .En(en_b), .RW(rw_b),
        .Data(data), .Ack(ack), .Done(done_b), .Err(err_b), .DbgAddr(dbg_addr), .DbgData(dbg_b)
    );

    always #5 clk = ~clk;

    int          sel = 0;
    logic [SA_WIDTH-1:0] cur_addr;
    logic        cur_en, cur_rw, cur_done, cur_err;
    logic [31:0] cur_dbg;
    assign cur_addr = (sel != 0) ? addr_b : addr_a;
    assign cur_en   = (sel != 0) ? en_b   : en_a;
    assign cur_rw   = (sel != 0) ? rw_b   : rw_a;
    assign cur_done = (sel != 0) ? done_b : done_a;
    assign cur_err  = (sel != 0) ? err_b  : err_a;
    assign cur_dbg  = (sel != 0) ? dbg_b  : dbg_a;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] mem [256];
    logic [31:0] m_regs [32];
    bit          m_err;
    int          m_cycles;
    int          exp_pc_q[$];
    int          plen_cur = 256;
    bit          chk_on = 1'b0;
    int          dly = 0;
    bit          ack_tied = 1'b0;
    int          wcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'd2, 26'(target)};
    endfunction

    localparam logic [31:0] c_HALT = 32'hFC00_0000;

    // Instruction-level reference: executes the program and records the
    // fetch-address sequence and the cycle count a run must take.
    task automatic model_run(input int plen, input int d);
        int pc, n, nxt, dst, rs, rt, rd, sh;
        logic [31:0] ir, a, b, res, simm;
        logic [5:0]  op, fn;
        bit wr, stop;
        pc = 0; n = 0; stop = 0;
        m_err = 0; m_cycles = 0;
        exp_pc_q.delete();
        while (!stop && n < 500) begin
            if (pc == plen) begin
                m_cycles += 1;
                stop = 1;
            end else begin
                ir = mem[pc];
                exp_pc_q.push_back(pc);
                n++;
                m_cycles += 4 + d;
                op = ir[31:26]; fn = ir[5:0];
                rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]); sh = int'(ir[10:6]);
                a = m_regs[rs]; b = m_regs[rt];
                simm = {{16{ir[15]}}, ir[15:0]};
                wr = 0; dst = rd; res = 0;
                nxt = (pc + 1) % 256;
                case (op)
                    6'd0: begin
                        wr = 1;
                        case (fn)
                            6'd0:  res = b << sh;
                            6'd2:  res = b >> sh;
                            6'd24: res = a * b;
                            6'd26: begin
                                if (b == 0) begin res = 32'hFFFF_FFFF; m_err = 1; end
                                else res = a / b;
                            end
                            6'd32: res = a + b;
                            6'd34: res = a - b;
                            default: begin wr = 0; m_err = 1; end
                        endcase
                    end
                    6'd8: begin wr = 1; dst = rt; res = a + simm; end
                    6'd4: if (a == b) nxt = (pc + 1 + int'($signed(simm))) & 255;
                    6'd2: nxt = int'(ir[7:0]);
                    6'd63: stop = 1;
                    default: m_err = 1;
                endcase
                if (wr && dst != 0) m_regs[dst] = res;
                pc = nxt;
            end
        end
    endtask

    // Memory responder: Ack after dly wait cycles, or held high when tied.
    always @(negedge clk) begin
        if (ack_tied) begin
            ack  = 1'b1;
            data = mem[cur_addr];
        end else if (cur_en) begin
            if (wcnt >= dly) begin
                ack  = 1'b1;
                data = mem[cur_addr];
            end else begin
                ack = 1'b0;
                wcnt++;
            end
        end else begin
            ack  = 1'b0;
            wcnt = 0;
        end
    end

    logic                prev_en = 1'b0;
    logic [SA_WIDTH-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("rw_low", {31'd0, cur_rw}, 32'd0);
            if (cur_done) check("en_while_done", {31'd0, cur_en}, 32'd0);
            if (cur_en) begin
                if (!prev_en) begin
                    if (exp_pc_q.size() == 0) check("unexpected_fetch", {24'd0, cur_addr}, 32'hFFFF_FFFF);
                    else check("fetch_addr", {24'd0, cur_addr}, 32'(exp_pc_q.pop_front()));
                end else begin
                    check("addr_stable", {24'd0, cur_addr}, {24'd0, prev_addr});
                end
                if (sel != 0) check("fetch_below_len", {31'd0, (int'(cur_addr) < plen_cur)}, 32'd1);
            end
        end
        prev_en   = cur_en;
        prev_addr = cur_addr;
    end

    task automatic rd_reg(input int i, output logic [31:0] v);
        dbg_addr = RA_WIDTH'(i);
        #1;
        v = cur_dbg;
    endtask

    task automatic run_prog(input int s, input int plen, input int d, input bit tied, output int cyc);
        logic [31:0] v;
        sel = s; plen_cur = plen; dly = d; ack_tied = tied;
        model_run(plen, d);
        chk_on = 1'b1;
        @(negedge clk);
        if (s == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        cyc = 0;
        while (!cur_done && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("done", {31'd0, cur_done}, 32'd1);
        check("cycles", 32'(cyc), 32'(m_cycles));
        check("fetches_left", 32'(exp_pc_q.size()), 32'd0);
        check("err", {31'd0, cur_err}, {31'd0, m_err});
        for (int i = 0; i < 32; i++) begin
            rd_reg(i, v);
            check($sformatf("reg%0d", i), v, m_regs[i]);
        end
        chk_on = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [31:0] v;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        #12;
        check("rst_en", {31'd0, en_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        check("rst_addr", {24'd0, addr_a}, 32'd0);
        rd_reg(1, v);
        check("rst_r1", v, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        mem[0] = enc_i(8, 0, 1, 5);
        mem[1] = enc_i(8, 0, 2, -3);
        mem[2] = enc_r(1, 2, 3, 0, 32);
        mem[3] = enc_r(2, 1, 4, 0, 34);
        mem[4] = enc_r(0, 1, 5, 4, 0);
        mem[5] = c_HALT;
        check("enc_addi", mem[0], 32'h2001_0005);
        check("enc_add", mem[2], 32'h0022_1820);

        run_prog(0, 256, 0, 1'b1, cyc);
        check("p1_cycles_lit", 32'(cyc), 32'd24);
        rd_reg(3, v); check("p1_r3_lit", v, 32'd2);
        rd_reg(4, v); check("p1_r4_lit", v, 32'hFFFF_FFF8);
        rd_reg(5, v); check("p1_r5_lit", v, 32'd80);

        run_prog(0, 256, 3, 1'b0, cyc);
        check("p1w_cycles_lit", 32'(cyc), 32'd42);
        rd_reg(3, v); check("p1w_r3_lit", v, 32'd2);
        rd_reg(4, v); check("p1w_r4_lit", v, 32'hFFFF_FFF8);

        // Asynchronous reset in the middle of a stalled fetch.
        sel = 0; dly = 1000; ack_tied = 1'b0;
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); @(negedge clk); start_a = 1'b0;
        cyc = 0;
        while (!en_a && cyc < 10) begin @(negedge clk); cyc++; end
        check("mid_fetch_en", {31'd0, en_a}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_en", {31'd0, en_a}, 32'd0);
        check("async_rst_done", {31'd0, done_a}, 32'd0);
        check("async_rst_addr", {24'd0, addr_a}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd_reg(i, v);
            check($sformatf("rst_reg%0d", i), v, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        @(negedge clk);

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = enc_i(8, 0, 1, 0);
        mem[1] = enc_i(8, 0, 2, 3);
        mem[2] = enc_i(8, 1, 1, 1);
        mem[3] = enc_i(4, 1, 2, 1);
        mem[4] = enc_j(2);
        mem[5] = c_HALT;
        run_prog(0, 256, 0, 1'b0, cyc);
        check("beq_cycles_lit", 32'(cyc), 32'd44);
        rd_reg(1, v); check("beq_r1_lit", v, 32'd3);
        check("beq_err_lit", {31'd0, err_a}, 32'd0);

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0]  = enc_i(8, 0, 1, 100);
        mem[1]  = enc_i(8, 0, 7, 7);
        mem[2]  = enc_i(8, 0, 2, -1);
        mem[3]  = enc_r(1, 0, 3, 0, 26);
        mem[4]  = enc_r(1, 7, 6, 0, 26);
        mem[5]  = enc_r(1, 1, 8, 0, 24);
        mem[6]  = enc_r(0, 2, 9, 28, 2);
        mem[7]  = enc_i(6'h2C, 0, 0, 0);
        mem[8]  = enc_i(8, 0, 0, 7);
        mem[9]  = enc_r(2, 1, 10, 0, 32);
        mem[10] = c_HALT;
        run_prog(0, 256, 1, 1'b0, cyc);
        rd_reg(3, v);  check("div0_r3_lit", v, 32'hFFFF_FFFF);
        check("div0_err_lit", {31'd0, err_a}, 32'd1);
        rd_reg(0, v);  check("r0_lit", v, 32'd0);
        rd_reg(6, v);  check("div_r6_lit", v, 32'd14);
        rd_reg(8, v);  check("mul_r8_lit", v, 32'd10000);
        rd_reg(9, v);  check("srl_r9_lit", v, 32'd15);
        rd_reg(10, v); check("add_wrap_r10_lit", v, 32'd99);

        // Fetch-limit instance: PROG_LEN = 4, no HALT inside the window.
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = enc_i(8, 1, 1, 1);
        mem[1] = enc_i(8, 1, 1, 1);
        mem[2] = enc_r(0, 0, 0, 0, 63);
        mem[3] = enc_i(8, 1, 1, 1);
        mem[4] = enc_i(8, 1, 1, 100);
        run_prog(1, 4, 0, 1'b0, cyc);
        check("plen_cycles_lit", 32'(cyc), 32'd17);
        rd_reg(1, v); check("plen_r1_lit", v, 32'd3);
        check("plen_err_lit", {31'd0, err_b}, 32'd1);

        mem[2] = enc_i(8, 1, 1, 1);
        run_prog(1, 4, 0, 1'b0, cyc);
        rd_reg(1, v); check("restart_r1_lit", v, 32'd7);
        check("restart_err_lit", {31'd0, err_b}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpp_core_p.md
Name: gpp_core_p

Overview:
- Parametrised successor to the team's multicycle MIPS-subset GPP.
- Fetches 32-bit instructions over a memory port with a wait-state handshake (Ack) and executes them against an internal register file of configurable depth.
- Adds BEQ, J, explicit HALT, hardwired R0, divide-by-zero/illegal-op error flag, Start-triggered runs and a register debug read port.
- Sits between instruction memory and the testbench/top level.

Parameters:
- D_WIDTH, 32, datapath and register width (>=16).
- SA_WIDTH, 8, instruction address width.
- RA_WIDTH, 5, register address width; register count = 2**RA_WIDTH.
- PROG_LEN, 256, fetch limit; reaching PC==PROG_LEN ends the run (<= 2**SA_WIDTH).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle run request, sampled in S_IDLE and S_HALT.
- Addr  out  SA_WIDTH  instruction address (PC).
- En  out  1  memory request.
- RW  out  1  always 0 (read).
- Data  in  32  instruction word, valid when Ack=1.
- Ack  in  1  memory response; ignored unless En=1.
- Done  out  1  run complete.
- Err  out  1  sticky error.
- DbgAddr  in  RA_WIDTH  debug register select.
- DbgData  out  D_WIDTH  combinational read of reg[DbgAddr]; R0 reads 0.

Behaviour:
- Reset (Rst=0, async): state S_IDLE; PC=0, IR=0; all registers 0; Addr=0, En=0, RW=0, Done=0, Err=0. En drops immediately on reset assertion, including mid-fetch.
- State machine: S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT.
- S_IDLE: waits for Start=1. Then PC=0, Err=0, Done=0, next S_FETCH. Registers are NOT cleared by Start.
- S_FETCH:
  - If PC==PROG_LEN: En=0, next S_HALT.
  - Otherwise: Addr=PC, En=1, held until Ack=1 is sampled. On that edge IR<=Data, En<=0, next S_DECODE.
  - Any number of wait cycles is allowed.
- S_DECODE (1 cycle): fields op=IR[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sh=[10:6], fn=[5:0], imm=IR[15:0]. Only the low RA_WIDTH bits of rs/rt/rd are used. Operands latched from the register file.
- S_EXEC (1 cycle): result computed and registered. Arithmetic wraps modulo 2**D_WIDTH.
  - op0 fn0 SLL: rd = rt << sh.
  - op0 fn2 SRL: rd = rt >> sh (logical).
  - op0 fn24 MUL: rd = low D_WIDTH bits of rs*rt, unsigned.
  - op0 fn26 DIV: rd = rs/rt, unsigned. If rt==0: result all-ones and Err<=1.
  - op0 fn32 ADD: rd = rs+rt.
  - op0 fn34 SUB: rd = rs-rt.
  - op8 ADDI: rt = rs + sext(imm).
  - op4 BEQ: if rs==rt, PC_next = PC+1+sext(imm); no register write.
  - op2 J: PC_next = IR[SA_WIDTH-1:0]; no register write.
  - op63 HALT: next S_HALT after S_WB.
  - Any other op/fn: Err<=1, no write, treated as NOP.
- S_WB (1 cycle):
  - Register write; writes to R0 are discarded.
  - PC<=PC_next, default PC+1. PC arithmetic wraps modulo 2**SA_WIDTH.
  - Next S_FETCH, or S_HALT for HALT.
- Latency: 4 cycles per instruction with zero-wait memory (Ack high in the first En cycle); each wait cycle adds 1.
- Branch/jump target >= PROG_LEN: the run ends at the next S_FETCH check.
- S_HALT: Done=1; En=0; registers readable via DbgData. Start=1 starts a new run as from S_IDLE, dropping Done the next cycle.
- Start outside S_IDLE/S_HALT: ignored.
- Err is sticky until Start or reset.

Test Plan:
- Reset mid-fetch (En=1, Ack held 0) -> En=0 same cycle, Done=0, DbgData=0 for all regs; after release and Start, fetch begins at Addr=0.
- Program ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SUB r4,r2,r1; SLL r5,r1,4; HALT, with Ack tied high -> r3=2, r4=0xFFFFFFF8, r5=80, Done after 24 cycles.
- Same program with Ack delayed 3 cycles per fetch -> identical register results; each instruction takes 7 cycles; Addr stable while En=1.
- BEQ loop: r1=0, r2=3; loop ADDI r1,r1,1; BEQ r1,r2,+1; J loop; HALT -> r1=3, Done=1, Err=0.
- DIV r3,r1,r0 then illegal op 0x2C -> r3=0xFFFFFFFF, Err=1; write to R0 via ADDI r0,r0,7 -> R0 reads 0.
- PROG_LEN=4 with no HALT in the program -> S_HALT entered after 4 instructions; Addr never reaches 4 with En=1; Start restarts the run with Err cleared.
